// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader.
//
// Receives a byte stream over a valid/ready handshake. The stream starts with
// a 2-byte little-endian word count N, followed by N 32-bit little-endian
// instruction words. Each completed word is written to instruction memory with
// a one-cycle write pulse. The core is held in reset until the last word has
// committed.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-low reset
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader accepts the byte (transfer = in_valid & in_ready)
//   reload     restart request, honoured only once loading is done or failed
//   mem_we     instruction-memory write enable, one pulse per word
//   mem_waddr  word index (not a byte address)
//   mem_wdata  instruction word
//   core_hold  high keeps the core in reset
//   done       load complete (level)
//   err        header count larger than the memory depth (level)
module imem_loader #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    HDR0, HDR1, DATA, FLUSH, DONE, ERROR
  } state_t;

  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t          state;
  state_t          state_nx;
  logic [15:0]     count;
  logic [ADDR_W:0] word_cnt;
  logic [1:0]      byte_cnt;
  logic [23:0]     asm_word;
  logic [15:0]     hdr_n;
  logic            hdr_zero;
  logic            hdr_over;
  logic            last_word;
  logic            ready_st;
  logic            hold_st;
  logic            accept;
  logic            reload_ok;

  // Full header value as it becomes known on the second header byte.
  assign hdr_n     = {in_data, count[7:0]};
  assign hdr_zero  = (hdr_n == 16'd0);
  assign hdr_over  = ({1'b0, hdr_n} > DEPTH);
  // word_cnt still holds the index of the word being completed.
  assign last_word = (16'(word_cnt) == count - 16'd1);

  assign accept    = in_valid & ready_st;
  assign reload_ok = reload & ((state == DONE) | (state == ERROR));

  // in_ready is gated by reset so it reads 0 while reset is asserted.
  assign in_ready  = ready_st & rst;
  assign core_hold = hold_st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HDR0;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ready_st = 1'b0;
    hold_st  = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      HDR0: begin
        ready_st = 1'b1;
        if (in_valid) state_nx = HDR1;
      end
      HDR1: begin
        ready_st = 1'b1;
        if (in_valid) begin
          if (hdr_zero)      state_nx = DONE;
          else if (hdr_over) state_nx = ERROR;
          else               state_nx = DATA;
        end
      end
      DATA: begin
        ready_st = 1'b1;
        if (in_valid && (byte_cnt == 2'd3) && last_word) state_nx = FLUSH;
      end
      FLUSH: begin
        state_nx = DONE;
      end
      DONE: begin
        hold_st = 1'b0;
        done    = 1'b1;
        if (reload) state_nx = HDR0;
      end
      ERROR: begin
        // Bytes keep being accepted and dropped so the host never stalls.
        ready_st = 1'b1;
        err      = 1'b1;
        if (reload) state_nx = HDR0;
      end
      default: state_nx = HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      asm_word  <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        unique case (state)
          HDR0: count[7:0]  <= in_data;
          HDR1: count[15:8] <= in_data;
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            unique case (byte_cnt)
              2'd0: asm_word[7:0]   <= in_data;
              2'd1: asm_word[15:8]  <= in_data;
              2'd2: asm_word[23:16] <= in_data;
              default: begin
                // Fourth byte completes the word; the write shows up next cycle.
                mem_we    <= 1'b1;
                mem_waddr <= word_cnt[ADDR_W-1:0];
                mem_wdata <= {in_data, asm_word};
                word_cnt  <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
              end
            endcase
          end
          default: ;
        endcase
      end
      if (reload_ok) begin
        count    <= '0;
        word_cnt <= '0;
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              reload = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: counts accepted bytes of the current load and derives
  // header, word index and byte lane from that count.
  int          m_nb;
  int          m_n;
  bit          m_done;
  bit          m_err;
  bit          m_flush;
  bit          m_we;
  int          m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_acc;
  int          mk;
  int          mj;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_nb = 0; m_n = 0; m_done = 0; m_err = 0; m_flush = 0;
      m_we = 0; m_wa = 0; m_wd = 0; m_acc = 0;
    end else begin
      m_we = 0;
      if (m_flush) begin
        m_flush = 0;
        m_done  = 1;
      end else if (m_done || m_err) begin
        if (reload) begin
          m_nb = 0; m_n = 0; m_done = 0; m_err = 0;
        end
      end else if (in_valid) begin
        mk = m_nb;
        m_nb++;
        if (mk == 0) begin
          m_n = int'(in_data);
        end else if (mk == 1) begin
          m_n += int'(in_data) * 256;
          if (m_n == 0) m_done = 1;
          else if (m_n > DEPTH) m_err = 1;
        end else begin
          mj = (mk - 2) % 4;
          m_acc[8*mj +: 8] = in_data;
          if (mj == 3) begin
            m_we = 1;
            m_wa = (mk - 2) / 4;
            m_wd = m_acc;
            if (m_wa == m_n - 1) m_flush = 1;
          end
        end
      end
    end
  end

  typedef struct {
    int          a;
    logic [31:0] d;
  } wr_t;
  wr_t  wr_log[$];
  int   cyc = 0;
  int   last_we_cyc = -100;
  int   done_cyc = -100;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    chk("in_ready", 32'(in_ready), 32'(rst && !m_done && !m_flush));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    if (m_we) begin
      chk("mem_waddr", 32'(mem_waddr), m_wa);
      chk("mem_wdata", mem_wdata, m_wd);
    end
    chk("core_hold", 32'(core_hold), 32'(!m_done));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    if (mem_we) begin
      wr_log.push_back('{a: int'(mem_waddr), d: mem_wdata});
      last_we_cyc = cyc;
    end
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
  end

  logic [31:0] prog[$];

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h not accepted in 50 cycles", b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic load(input int n, input int maxgap);
    logic [15:0] nn;
    logic [31:0] w;
    nn = n[15:0];
    send(nn[7:0], $urandom_range(maxgap, 0));
    send(nn[15:8], $urandom_range(maxgap, 0));
    foreach (prog[i]) begin
      w = prog[i];
      for (int b = 0; b < 4; b++) send(w[8*b +: 8], $urandom_range(maxgap, 0));
    end
  endtask

  task automatic wait_level(input string name);
    int t;
    t = 0;
    while (!(done || err) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_settle"}, 32'(t < 200), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_reload;
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  int zero_writes;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("hdr0_in_ready", 32'(in_ready), 32'd1);

    // Three words, no gaps.
    wr_log.delete();
    prog = '{32'h00A00093, 32'h01400113, 32'h02800193};
    load(3, 0);
    idle(1);
    wait_level("t1");
    chk("t1_nwr", wr_log.size(), 3);
    chk("t1_a0", wr_log[0].a, 0);
    chk("t1_d0", wr_log[0].d, 32'h00A00093);
    chk("t1_a2", wr_log[2].a, 2);
    chk("t1_d2", wr_log[2].d, 32'h02800193);
    chk("t1_release_lat", done_cyc - last_we_cyc, 1);
    chk("t1_hold", 32'(core_hold), 32'd0);

    // Same program with random gaps.
    do_reload();
    wr_log.delete();
    load(3, 5);
    idle(1);
    wait_level("t2");
    chk("t2_nwr", wr_log.size(), 3);
    chk("t2_d1", wr_log[1].d, 32'h01400113);
    chk("t2_release_lat", done_cyc - last_we_cyc, 1);

    // Empty program.
    do_reload();
    wr_log.delete();
    prog.delete();
    load(0, 0);
    idle(1);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_hold", 32'(core_hold), 32'd0);
    chk("t3_nwr", wr_log.size(), 0);

    // Oversized header, then flood of bytes, then recover.
    do_reload();
    wr_log.delete();
    load(513, 0);
    idle(1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_hold", 32'(core_hold), 32'd1);
    for (int i = 0; i < 20; i++) send(8'(i * 7), 0);
    idle(1);
    chk("t4_nwr", wr_log.size(), 0);
    do_reload();
    prog = '{32'h00500113};
    load(1, 0);
    idle(1);
    wait_level("t4b");
    chk("t4b_nwr", wr_log.size(), 1);
    chk("t4b_a0", wr_log[0].a, 0);
    chk("t4b_d0", wr_log[0].d, 32'h00500113);
    chk("t4b_done", 32'(done), 32'd1);
    chk("t4b_err", 32'(err), 32'd0);

    // Reset in the middle of the second word.
    do_reload();
    wr_log.delete();
    send(8'h02, 0);
    send(8'h00, 0);
    send(8'h44, 0); send(8'h33, 0); send(8'h22, 0); send(8'h11, 0);
    send(8'h88, 0); send(8'h77, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_mem_we", 32'(mem_we), 32'd0);
    chk("t5_waddr", 32'(mem_waddr), 32'd0);
    chk("t5_wdata", mem_wdata, 32'd0);
    chk("t5_hold", 32'(core_hold), 32'd1);
    chk("t5_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    chk("t5_nwr", wr_log.size(), 1);
    chk("t5_d0", wr_log[0].d, 32'h11223344);
    prog = '{32'hDEADBEEF};
    load(1, 3);
    idle(1);
    wait_level("t5b");
    chk("t5b_nwr", wr_log.size(), 2);
    chk("t5b_a", wr_log[1].a, 0);
    chk("t5b_d", wr_log[1].d, 32'hDEADBEEF);

    // Full-depth program.
    do_reload();
    wr_log.delete();
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back(32'h1000_0000 + 32'(i) * 3);
    load(DEPTH, 0);
    idle(1);
    wait_level("t6");
    chk("t6_nwr", wr_log.size(), DEPTH);
    chk("t6_last_a", wr_log[wr_log.size()-1].a, 511);
    chk("t6_last_d", wr_log[wr_log.size()-1].d, 32'h1000_05FD);
    zero_writes = 0;
    foreach (wr_log[i]) if (wr_log[i].a == 0) zero_writes++;
    chk("t6_addr0_once", zero_writes, 1);
    chk("t6_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
